// File: rtl/i2s_tx_serializer_if.sv
// Stereo sample handoff into the I2S serializer: one left/right pair per
// transfer, accepted on sampleValid && sampleReady.
interface i2s_tx_serializer_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] leftSampleIn;
  logic [SAMPLE_WIDTH-1:0] rightSampleIn;
  logic                    sampleValid;
  logic                    sampleReady;

  modport master (
    output leftSampleIn,
    output rightSampleIn,
    output sampleValid,
    input  sampleReady
  );

  modport slave (
    input  leftSampleIn,
    input  rightSampleIn,
    input  sampleValid,
    output sampleReady
  );
endinterface

// File: rtl/i2s_tx_serializer.sv
// Serializes one stereo pair per frame onto I2S (bclk/lrclk/sdata, MSB one bclk after
// the lrclk edge), with a one-pair pending buffer and a muted frame plus underrun pulse when empty.
module i2s_tx_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  i2s_tx_serializer_if.slave    samples,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  frameStart,
  output logic                  underrun
);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [BW-1:0]           next_bit;
  logic [BW-1:0]           slot_pos;
  logic [SAMPLE_WIDTH-1:0] pend_left;
  logic [SAMPLE_WIDTH-1:0] pend_right;
  logic [SAMPLE_WIDTH-1:0] tx_left;
  logic [SAMPLE_WIDTH-1:0] tx_right;
  logic [SAMPLE_WIDTH-1:0] chan;
  logic                    pending_full;
  logic                    accept;
  logic                    fall;
  logic                    right_slot;
  logic                    serial_bit;

  assign samples.sampleReady = !pending_full && !reset;
  assign accept = samples.sampleValid && samples.sampleReady;
  assign fall   = (div_cnt == DIV_LAST) && bclk;

  // Bit for the slot position that becomes current on this falling event;
  // position 0 of each slot is the I2S delay bit and carries 0.
  always_comb begin
    next_bit   = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    right_slot = (next_bit >= SLOT_LEN);
    slot_pos   = right_slot ? (next_bit - SLOT_LEN) : next_bit;
    chan       = right_slot ? tx_right : tx_left;
    serial_bit = 1'b0;
    for (int i = 1; i <= SAMPLE_WIDTH; i++) begin
      if (slot_pos == BW'(i)) serial_bit = chan[SAMPLE_WIDTH-i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      bit_cnt      <= LAST_BIT;
      bclk         <= 1'b0;
      lrclk        <= 1'b1;
      sdata        <= 1'b0;
      frameStart   <= 1'b0;
      underrun     <= 1'b0;
      pending_full <= 1'b0;
      pend_left    <= '0;
      pend_right   <= '0;
      tx_left      <= '0;
      tx_right     <= '0;
    end else begin
      frameStart <= 1'b0;
      underrun   <= 1'b0;

      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (fall) begin
        bit_cnt <= next_bit;
        lrclk   <= right_slot;
        sdata   <= serial_bit;
        if (next_bit == '0) begin
          frameStart <= 1'b1;
          if (pending_full) begin
            tx_left      <= pend_left;
            tx_right     <= pend_right;
            pending_full <= 1'b0;
          end else begin
            tx_left  <= '0;
            tx_right <= '0;
            underrun <= 1'b1;
          end
        end
      end

      // Only reachable with pending empty, so it never races the clear above.
      if (accept) begin
        pend_left    <= samples.leftSampleIn;
        pend_right   <= samples.rightSampleIn;
        pending_full <= 1'b1;
      end
    end
  end
endmodule
